requant_act_mc: RTL and testbench

- Multi-channel requantization and activation stage for the int8 inference datapath.
- Sits between the MAC accumulator array and the activation buffer.
- Converts each IN_W-bit accumulator to OUT_W-bit activations using per-channel bias, scale and shift held in internal tables.
- Selectable activation mode, round-half-up rounding, valid/ready backpressure, fully pipelined at one sample per cycle.

---
 rtl/requant_act_mc.sv | 216 +++++++++++++++++++++
 tb/tb_requant_act_mc.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/requant_act_mc.sv
// Multi-channel requantization + activation stage: bias, scale, rounding shift, zero point, clamp.
// Optional macro REQUANT_SAT_CNT_EN adds saturation event counters (o_sat_hi_cnt, o_sat_lo_cnt, sat_clr).
module requant_act_mc #(
    parameter int IN_W    = 32,
    parameter int BIAS_W  = 32,
    parameter int SCALE_W = 32,
    parameter int SHIFT_W = 6,
    parameter int OUT_W   = 8,
    parameter int NUM_CH  = 16,
    parameter int CH_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [BIAS_W-1:0]  cfg_bias,
    input  logic [SCALE_W-1:0] cfg_scale,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic [1:0]         i_mode,
    input  logic [OUT_W-1:0]   i_zero_point,
    input  logic [OUT_W-1:0]   i_act_max,
    input  logic               i_valid,
    output logic               i_ready,
    input  logic [IN_W-1:0]    i_acc,
    input  logic [CH_W-1:0]    i_ch,
`ifdef REQUANT_SAT_CNT_EN
    input  logic               sat_clr,
    output logic [31:0]        o_sat_hi_cnt,
    output logic [31:0]        o_sat_lo_cnt,
`endif
    output logic               o_valid,
    input  logic               o_ready,
    output logic [OUT_W-1:0]   o_data,
    output logic [CH_W-1:0]    o_ch
);

    localparam int BW = IN_W + 1;            // biased accumulator
    localparam int PW = IN_W + SCALE_W + 1;  // full product
    localparam int RW = PW + 1;              // product plus rounding headroom
    localparam int VW = RW + 1;              // after zero-point add

    localparam logic [CH_W:0]          NUM_CH_L  = NUM_CH[CH_W:0];
    localparam logic signed [VW-1:0]   OUT_MAX_C = {{(VW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [VW-1:0]   OUT_MIN_C = {{(VW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [RW-1:0]          ONE_RW_C  = {{(RW-1){1'b0}}, 1'b1};
    localparam logic [SHIFT_W-1:0]     ONE_SH_C  = {{(SHIFT_W-1){1'b0}}, 1'b1};

    logic [BIAS_W-1:0]  bias_tbl_r  [NUM_CH];
    logic [SCALE_W-1:0] scale_tbl_r [NUM_CH];
    logic [SHIFT_W-1:0] shift_tbl_r [NUM_CH];

    logic               en_s;
    logic               s1_valid_r, s2_valid_r, s3_valid_r;
    logic [IN_W-1:0]    s1_acc_r;
    logic [BIAS_W-1:0]  s1_bias_r;
    logic [SCALE_W-1:0] s1_scale_r, s2_scale_r;
    logic [SHIFT_W-1:0] s1_shift_r, s2_shift_r, s3_shift_r;
    logic [CH_W-1:0]    s1_ch_r, s2_ch_r, s3_ch_r;
    logic [BW-1:0]      biased_s, s2_biased_r;
    logic signed [PW-1:0] mul_a_s, mul_b_s, prod_s;
    logic [PW-1:0]      s3_prod_r;
    logic [RW-1:0]      prod_ext_s, half_s;
    logic signed [RW-1:0] sum_s, rnd_s;
    logic signed [VW-1:0] v_s, lo_s, hi_s;
    logic [OUT_W-1:0]   res_s;

    assign en_s    = !o_valid || o_ready;
    assign i_ready = en_s;

    // Channel table write port; independent of the pipeline enable, out-of-range indices dropped
    always_ff @(posedge clk) begin
        if (cfg_we && ({1'b0, cfg_ch} < NUM_CH_L)) begin
            bias_tbl_r[cfg_ch]  <= cfg_bias;
            scale_tbl_r[cfg_ch] <= cfg_scale;
            shift_tbl_r[cfg_ch] <= cfg_shift;
        end
    end

    // Stage valid bits advance together whenever the pipeline is enabled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
            s3_valid_r <= 1'b0;
            o_valid    <= 1'b0;
        end else if (en_s) begin
            s1_valid_r <= i_valid;
            s2_valid_r <= s1_valid_r;
            s3_valid_r <= s2_valid_r;
            o_valid    <= s3_valid_r;
        end
    end

    // Datapath registers load only for valid data; the table read sees pre-write contents
    always_ff @(posedge clk) begin
        if (en_s && i_valid) begin
            s1_acc_r   <= i_acc;
            s1_ch_r    <= i_ch;
            s1_bias_r  <= bias_tbl_r[i_ch];
            s1_scale_r <= scale_tbl_r[i_ch];
            s1_shift_r <= shift_tbl_r[i_ch];
        end
        if (en_s && s1_valid_r) begin
            s2_biased_r <= biased_s;
            s2_scale_r  <= s1_scale_r;
            s2_shift_r  <= s1_shift_r;
            s2_ch_r     <= s1_ch_r;
        end
        if (en_s && s2_valid_r) begin
            s3_prod_r  <= prod_s;
            s3_shift_r <= s2_shift_r;
            s3_ch_r    <= s2_ch_r;
        end
    end

    // Bias add and full-width signed multiply
    always_comb begin
        biased_s = {s1_acc_r[IN_W-1], s1_acc_r}
                 + {{(BW-BIAS_W){s1_bias_r[BIAS_W-1]}}, s1_bias_r};
        mul_a_s  = {{(PW-BW){s2_biased_r[BW-1]}}, s2_biased_r};
        mul_b_s  = {{(PW-SCALE_W){s2_scale_r[SCALE_W-1]}}, s2_scale_r};
        prod_s   = mul_a_s * mul_b_s;
    end

    // Round-half-up shift, zero point, then clamp at full width before truncation
    always_comb begin
        prod_ext_s = {s3_prod_r[PW-1], s3_prod_r};
        half_s     = {RW{1'b0}};
        if (s3_shift_r != {SHIFT_W{1'b0}}) begin
            half_s = ONE_RW_C << (s3_shift_r - ONE_SH_C);
        end else begin
            half_s = {RW{1'b0}};
        end
        sum_s = prod_ext_s + half_s;
        rnd_s = sum_s >>> s3_shift_r;
        v_s   = {rnd_s[RW-1], rnd_s} + {{(VW-OUT_W){i_zero_point[OUT_W-1]}}, i_zero_point};

        lo_s = OUT_MIN_C;
        hi_s = OUT_MAX_C;
        case (i_mode)
            2'd0: begin
                lo_s = OUT_MIN_C;
                hi_s = OUT_MAX_C;
            end
            2'd2: begin
                lo_s = {VW{1'b0}};
                if (i_act_max[OUT_W-1]) begin
                    hi_s = {VW{1'b0}};
                end else begin
                    hi_s = {{(VW-OUT_W){1'b0}}, i_act_max};
                end
            end
            default: begin
                lo_s = {VW{1'b0}};
                hi_s = OUT_MAX_C;
            end
        endcase

        res_s = v_s[OUT_W-1:0];
        if (v_s < lo_s) begin
            res_s = lo_s[OUT_W-1:0];
        end else if (v_s > hi_s) begin
            res_s = hi_s[OUT_W-1:0];
        end else begin
            res_s = v_s[OUT_W-1:0];
        end
    end

    // Output register holds while the consumer stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_data <= {OUT_W{1'b0}};
            o_ch   <= {CH_W{1'b0}};
        end else if (en_s && s3_valid_r) begin
            o_data <= res_s;
            o_ch   <= s3_ch_r;
        end
    end

`ifdef REQUANT_SAT_CNT_EN
    logic sat_hi_s, sat_lo_s, o_sat_hi_r, o_sat_lo_r;

    // Classify the stage-4 result; ReLU clipping of negatives lands on lo
    always_comb begin
        sat_hi_s = (v_s > hi_s);
        sat_lo_s = (v_s < lo_s);
    end

    // Saturation flags travel alongside the output data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_sat_hi_r <= 1'b0;
            o_sat_lo_r <= 1'b0;
        end else if (en_s && s3_valid_r) begin
            o_sat_hi_r <= sat_hi_s;
            o_sat_lo_r <= sat_lo_s;
        end
    end

    // Saturating event counters; clear wins over increment
    always_ff @(posedge clk) begin
        if (!rst_n || sat_clr) begin
            o_sat_hi_cnt <= 32'd0;
            o_sat_lo_cnt <= 32'd0;
        end else if (o_valid && o_ready) begin
            if (o_sat_hi_r && (o_sat_hi_cnt != 32'hFFFF_FFFF)) begin
                o_sat_hi_cnt <= o_sat_hi_cnt + 32'd1;
            end
            if (o_sat_lo_r && (o_sat_lo_cnt != 32'hFFFF_FFFF)) begin
                o_sat_lo_cnt <= o_sat_lo_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_requant_act_mc.sv
// Self-checking bench for requant_act_mc: directed vector table, multi-cycle corner sequences,
// and randomized traffic against a wide-integer reference model.
module tb_requant_act_mc;

    logic        clk = 1'b0;
    logic        rst_n, cfg_we, i_valid, i_ready, o_valid, o_ready;
    logic [3:0]  cfg_ch, i_ch, o_ch;
    logic [31:0] cfg_bias, cfg_scale, i_acc;
    logic [5:0]  cfg_shift;
    logic [1:0]  i_mode;
    logic [7:0]  i_zero_point, i_act_max, o_data;
`ifdef REQUANT_SAT_CNT_EN
    logic        sat_clr = 1'b0;
    logic [31:0] o_sat_hi_cnt, o_sat_lo_cnt;
`endif

    always #5 clk = ~clk;

    requant_act_mc dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_bias(cfg_bias),
        .cfg_scale(cfg_scale), .cfg_shift(cfg_shift),
        .i_mode(i_mode), .i_zero_point(i_zero_point), .i_act_max(i_act_max),
        .i_valid(i_valid), .i_ready(i_ready), .i_acc(i_acc), .i_ch(i_ch),
`ifdef REQUANT_SAT_CNT_EN
        .sat_clr(sat_clr), .o_sat_hi_cnt(o_sat_hi_cnt), .o_sat_lo_cnt(o_sat_lo_cnt),
`endif
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_ch(o_ch)
    );

    typedef struct { int d; int ch; } exp_t;
    typedef struct { int ch; longint acc; int mode; int zp; int amax; int exp_d; } vec_t;

    int     checks = 0, failures = 0;
    longint m_bias [16];
    longint m_scale[16];
    int     m_shift[16];
    int     cur_mode, cur_zp, cur_amax;
    exp_t   sb[$];
    int     got_q[$];
    bit     prev_stall = 1'b0, last_accept = 1'b0;
    int     prev_data, prev_ch;
    vec_t   vecs[17];

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Reference: exact integer arithmetic straight from the requantization rules
    function automatic int ref_out(input longint acc, input longint bias, input longint scale,
                                   input int sh, input int mode, input int zp, input int amax);
        logic signed [127:0] b, p, r, v;
        int lo, hi;
        b = acc;
        b = b + bias;
        p = b * scale;
        if (sh > 0) r = (p + (128'sd1 <<< (sh - 1))) >>> sh;
        else        r = p;
        v = r + zp;
        case (mode)
            0:       begin lo = -128; hi = 127; end
            2:       begin lo = 0; hi = (amax < 0) ? 0 : ((amax > 127) ? 127 : amax); end
            default: begin lo = 0; hi = 127; end
        endcase
        if (v < lo) return lo;
        if (v > hi) return hi;
        return int'(v);
    endfunction

    task automatic set_layer(input int mode, input int zp, input int amax);
        cur_mode = mode; cur_zp = zp; cur_amax = amax;
        i_mode = 2'(mode); i_zero_point = 8'(zp); i_act_max = 8'(amax);
    endtask

    // One clock: observe handshakes mid-cycle, update scoreboard/model, advance to next negedge
    task automatic tick();
        exp_t e;
        #1;
        last_accept = 1'b0;
        if (rst_n) begin
            if (prev_stall) begin
                chk("stall_hold_valid", o_valid, 1);
                chk("stall_hold_data", $signed(o_data), prev_data);
                chk("stall_hold_ch", o_ch, prev_ch);
            end
            if (o_valid && !o_ready) chk("iready_low_when_stalled", i_ready, 0);
            if (o_valid && o_ready) begin
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_output got_data=%0d got_ch=%0d", $signed(o_data), o_ch);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", $signed(o_data), e.d);
                    chk("out_ch", o_ch, e.ch);
                end
                got_q.push_back(int'($signed(o_data)));
            end
            if (i_valid && i_ready) begin
                e.d  = ref_out(longint'($signed(i_acc)), m_bias[i_ch], m_scale[i_ch], m_shift[i_ch],
                               cur_mode, cur_zp, cur_amax);
                e.ch = int'(i_ch);
                sb.push_back(e);
                last_accept = 1'b1;
            end
            prev_stall = o_valid && !o_ready;
            prev_data  = int'($signed(o_data));
            prev_ch    = int'(o_ch);
        end else begin
            prev_stall = 1'b0;
        end
        if (cfg_we) begin
            m_bias[cfg_ch]  = longint'($signed(cfg_bias));
            m_scale[cfg_ch] = longint'($signed(cfg_scale));
            m_shift[cfg_ch] = int'(cfg_shift);
        end
        @(negedge clk);
    endtask

    task automatic cfg_write(input int ch, input longint b, input longint s, input int sh);
        cfg_we = 1'b1; cfg_ch = 4'(ch); cfg_bias = 32'(b); cfg_scale = 32'(s); cfg_shift = 6'(sh);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int edges, n;
        set_layer(v.mode, v.zp, v.amax);
        i_ch = 4'(v.ch); i_acc = 32'(v.acc); i_valid = 1'b1; o_ready = 1'b1;
        n = got_q.size();
        tick();
        chk("vec_accepted", last_accept, 1);
        i_valid = 1'b0;
        edges = 1;
        repeat (12) begin
            tick();
            if (got_q.size() > n) break;
            edges++;
        end
        chk("vec_latency", edges, 4);
        if (got_q.size() > n) chk("vec_data", got_q[n], v.exp_d);
        else                  chk("vec_data_missing", got_q.size(), n + 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int k, cyc, n;
        vecs[0]  = '{3,   100, 1,    0,   0,   64};
        vecs[1]  = '{0,     3, 0,    0,   0,    2};
        vecs[2]  = '{0,    -3, 0,    0,   0,   -1};
        vecs[3]  = '{0,    -3, 1,    0,   0,    0};
        vecs[4]  = '{1,  1000, 0,    0,   0,  127};
        vecs[5]  = '{1,  1000, 2,    0,   6,    6};
        vecs[6]  = '{1, -1000, 0,    0,   0, -128};
        vecs[7]  = '{0,    10, 0,   -3,   0,    2};
        vecs[8]  = '{1,  1000, 2,    0,  -5,    0};
        vecs[9]  = '{0,    -3, 3,    0,   0,    0};
        vecs[10] = '{4,    20, 0,    0,   0,   45};
        vecs[11] = '{4,   100, 1,    0,   0,  127};
        vecs[12] = '{1,   -50, 0,   20,   0,  -30};
        vecs[13] = '{1,   200, 0, -100,   0,  100};
        vecs[14] = '{1,     5, 2,    0, 127,    5};
        vecs[15] = '{0,     1, 0,    0,   0,    1};
        vecs[16] = '{0,    -1, 0,    0,   0,    0};

        rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = 4'd0; cfg_bias = 32'd0; cfg_scale = 32'd0;
        cfg_shift = 6'd0; i_valid = 1'b0; i_acc = 32'd0; i_ch = 4'd0; o_ready = 1'b1;
        set_layer(0, 0, 0);
        for (int c = 0; c < 16; c++) begin m_bias[c] = 0; m_scale[c] = 0; m_shift[c] = 0; end
        repeat (3) @(negedge clk);
        chk("reset_o_valid", o_valid, 0);
        chk("reset_o_data", o_data, 0);
        chk("reset_o_ch", o_ch, 0);
        chk("reset_i_ready", i_ready, 1);
        rst_n = 1'b1;

        cfg_write(0, 0, 64'sd1 << 30, 31);
        cfg_write(1, 0, 64'sd1 << 30, 30);
        cfg_write(2, 0, 64'sd1 << 30, 30);
        cfg_write(3, 28, 64'sd1 << 30, 31);
        cfg_write(4, -5, 3, 0);
        for (int v = 0; v < 17; v++) run_vec(vecs[v]);

        // Back-to-back across all channels with o_ready pattern 1,0,0,1
        set_layer(0, 0, 0);
        for (int c = 0; c < 16; c++) cfg_write(c, c * 10 - 80, 64'sd1 << 30, 31);
        n = got_q.size(); k = 0; cyc = 0;
        while (k < 16 && cyc < 200) begin
            i_valid = 1'b1; i_ch = 4'(k); i_acc = 32'(k * 7 - 50);
            o_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            tick();
            if (last_accept) k++;
            cyc++;
        end
        i_valid = 1'b0;
        repeat (40) begin
            o_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            tick();
            cyc++;
        end
        o_ready = 1'b1;
        repeat (4) tick();
        chk("b2b_out_count", got_q.size() - n, 16);
        chk("b2b_sb_empty", sb.size(), 0);

        // Table write colliding with a same-channel acceptance
        cfg_write(2, 0, 64'sd1 << 30, 30);
        n = got_q.size();
        i_valid = 1'b1; i_ch = 4'd2; i_acc = 32'd50; o_ready = 1'b1;
        cfg_we = 1'b1; cfg_ch = 4'd2; cfg_bias = 32'd0; cfg_scale = 32'h2000_0000; cfg_shift = 6'd30;
        tick();
        cfg_we = 1'b0;
        tick();
        i_valid = 1'b0;
        repeat (8) tick();
        chk("wrcol_count", got_q.size() - n, 2);
        if (got_q.size() >= n + 2) begin
            chk("wrcol_old_scale", got_q[n], 50);
            chk("wrcol_new_scale", got_q[n + 1], 25);
        end

        // Reset with three samples in flight
        i_valid = 1'b1; o_ready = 1'b1;
        for (int s = 0; s < 3; s++) begin i_ch = 4'(s); i_acc = 32'(s * 11); tick(); end
        i_valid = 1'b0; rst_n = 1'b0;
        tick();
        chk("midrst_o_valid", o_valid, 0);
        chk("midrst_o_data", o_data, 0);
        sb.delete();
        rst_n = 1'b1;
        for (int s = 0; s < 10; s++) begin
            tick();
            chk("midrst_no_stale", o_valid, 0);
        end

        // Randomized batches with random backpressure and occasional table rewrites
        for (int b = 0; b < 4; b++) begin
            set_layer($urandom_range(0, 3), int'($urandom_range(0, 255)) - 128,
                      int'($urandom_range(0, 255)) - 128);
            for (int c = 0; c < 16; c++)
                cfg_write(c,
                    $urandom_range(0, 1) ? longint'($signed($urandom)) : longint'($urandom_range(0, 2000)) - 1000,
                    $urandom_range(0, 1) ? longint'($signed($urandom)) : (64'sd1 << $urandom_range(16, 30)),
                    $urandom_range(0, 1) ? $urandom_range(0, 63) : $urandom_range(24, 34));
            for (int t = 0; t < 300; t++) begin
                i_valid = ($urandom_range(0, 3) != 0);
                i_ch    = 4'($urandom_range(0, 15));
                i_acc   = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 4000)) - 32'd2000;
                o_ready = ($urandom_range(0, 3) != 0);
                cfg_we  = ($urandom_range(0, 19) == 0);
                cfg_ch  = 4'($urandom_range(0, 15));
                cfg_bias  = 32'($urandom_range(0, 2000)) - 32'd1000;
                cfg_scale = 32'd1 << $urandom_range(16, 30);
                cfg_shift = 6'($urandom_range(20, 34));
                tick();
            end
            i_valid = 1'b0; cfg_we = 1'b0; o_ready = 1'b1;
            repeat (10) tick();
            chk("rand_drain_empty", sb.size(), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
